ge_seq_individual: RTL and testbench

- Parametrised, sequential successor to the fixed combinational GE individuals.
- Executes a loadable program of register-transfer bitwise instructions over NREG working registers of WIDTH bits, one instruction per clock.
- Sits between the GE evaluation harness (program load, operand vectors) and the fitness scorer (result vectors).
- Uses valid/ready handshakes on both sides, so one evolved program can be re-evaluated on many operand sets without regenerating RTL.

---
 rtl/ge_seq_individual.sv | 135 +++++++++++++
 tb/tb_ge_seq_individual.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ge_seq_individual.sv
// Sequential GE individual: runs a loaded program of bitwise register-transfer instructions
// over NREG working registers, one instruction per clock, with valid/ready on both sides.
module ge_seq_individual #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned NREG       = 4,
   parameter int unsigned PROG_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               prog_we,
   input  logic [$clog2(PROG_DEPTH)-1:0]      prog_addr,
   input  logic [4+2*$clog2(NREG)-1:0]        prog_data,
   input  logic [$clog2(PROG_DEPTH):0]        prog_len,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NREG*WIDTH-1:0]              in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NREG*WIDTH-1:0]              out_data,
   output logic                               busy
);

   localparam int unsigned A  = $clog2(NREG);
   localparam int unsigned P  = $clog2(PROG_DEPTH);
   localparam int unsigned IW = 4 + 2 * A;

   localparam logic [P:0] LenMax = PROG_DEPTH[P:0];
   localparam logic [P:0] LenOne = {{P{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
   typedef enum logic [2:0] {OpNop, OpMov, OpLnot, OpAnd, OpOr, OpXor, OpBnot, OpHalt} op_e;

   logic [IW-1:0] mem [PROG_DEPTH];

   state_e                       state_q, state_d;
   logic [P-1:0]                 pc_q, pc_d;
   logic [P:0]                   len_q, len_d;
   logic [NREG-1:0][WIDTH-1:0]   regs_q, regs_d;
   logic [NREG-1:0][WIDTH-1:0]   opnd_q, opnd_d;

   logic [IW-1:0]    instr;
   op_e              op;
   logic [A-1:0]     dst, src;
   logic             src_in;
   logic [WIDTH-1:0] s, d;

   assign instr  = mem[pc_q];
   assign op     = op_e'(instr[IW-1 -: 3]);
   assign dst    = instr[IW-4 -: A];
   assign src_in = instr[A];
   assign src    = instr[A-1:0];

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_data  = regs_q;

   // Program memory is deliberately not reset; it survives a reset abort.
   always_ff @(posedge clk) begin
      if (prog_we && state_q == StIdle) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      regs_d  = regs_q;
      opnd_d  = opnd_q;
      s       = src_in ? opnd_q[src] : regs_q[src];
      d       = regs_q[dst];

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               regs_d  = in_data;
               opnd_d  = in_data;
               len_d   = (prog_len > LenMax) ? LenMax : prog_len;
               pc_d    = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // An empty program still spends one cycle here so the minimum latency is one edge.
            if (len_q == '0) begin
               state_d = StDone;
            end else begin
               case (op)
                  OpMov:   d = s;
                  OpLnot:  d = WIDTH'(s == '0);
                  OpAnd:   d = d & s;
                  OpOr:    d = d | s;
                  OpXor:   d = d ^ s;
                  OpBnot:  d = ~s;
                  default: d = regs_q[dst];
               endcase
               if (op == OpHalt) begin
                  state_d = StDone;
               end else begin
                  regs_d[dst] = d;
                  if ({1'b0, pc_q} == len_q - LenOne) begin
                     state_d = StDone;
                  end else begin
                     pc_d = pc_q + 1'b1;
                  end
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= '0;
         len_q   <= '0;
         regs_q  <= '0;
         opnd_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         regs_q  <= regs_d;
         opnd_q  <= opnd_d;
      end
   end

endmodule

// File: tb/tb_ge_seq_individual.sv
// Directed bench for ge_seq_individual (WIDTH=16, NREG=4, PROG_DEPTH=16).
module tb_ge_seq_individual;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data;
   logic [4:0]  prog_len;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int lat;

   localparam logic [63:0] VecA = 64'hAAAA_3000_0F0F_00FF;
   localparam logic [63:0] VecB = 64'hAAAA_0000_0F0F_00FF;

   ge_seq_individual #(.WIDTH(16), .NREG(4), .PROG_DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .prog_len  (prog_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] enc(input int op, input int dst, input int sin, input int src);
      logic [7:0] w;
      w = {op[2:0], dst[1:0], sin[0], src[1:0]};
      return w;
   endfunction

   task automatic wr(input int addr, input logic [7:0] data);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = addr[3:0];
      prog_data = data;
      @(posedge clk);
      #1 prog_we = 1'b0;
   endtask

   task automatic start(input logic [63:0] vec, input logic [4:0] len);
      @(negedge clk);
      check("in_ready_before_accept", in_ready, 1);
      in_data  = vec;
      prog_len = len;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(output int l);
      int guard;
      guard = 0;
      while (!out_valid && guard < 60) begin
         @(posedge clk);
         #1 guard++;
      end
      l = cyc - t0;
   endtask

   task automatic ack();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("ack_out_valid", out_valid, 0);
      check("ack_in_ready", in_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 64'h0);
      rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);

      // LNOT r3,in2; AND r1,in2; OR r0,r2; AND r0,in1; OR r1,in2; AND r3,in0; OR r0,r2
      wr(0, enc(2, 3, 1, 2));
      wr(1, enc(3, 1, 1, 2));
      wr(2, enc(4, 0, 0, 2));
      wr(3, enc(3, 0, 1, 1));
      wr(4, enc(4, 1, 1, 2));
      wr(5, enc(3, 3, 1, 0));
      wr(6, enc(4, 0, 0, 2));

      start(VecA, 5'd7);
      wait_done(lat);
      check("progA_latency", lat, 7);
      check("progA_out", out_data, 64'h0000_3000_3000_300F);

      // Backpressure: result and handshake held while out_ready stays low
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_data", out_data, 64'h0000_3000_3000_300F);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = VecB;
      prog_len  = 5'd7;
      @(posedge clk);
      #1 out_ready = 1'b0;
      in_valid = 1'b0;
      check("handoff_out_valid", out_valid, 0);
      check("handoff_no_same_cycle_accept", busy, 0);

      // Second vector; write of HALT to address 0 during RUN must be ignored
      start(VecB, 5'd7);
      wr(0, enc(7, 0, 0, 0));
      wait_done(lat);
      check("progB_latency", lat, 7);
      check("progB_out", out_data, 64'h0001_0000_0000_000F);
      ack();

      start(VecA, 5'd7);
      wait_done(lat);
      check("rerun_latency", lat, 7);
      check("rerun_out", out_data, 64'h0000_3000_3000_300F);
      ack();

      // Asynchronous abort in the third cycle of RUN
      start(VecA, 5'd7);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_regs", out_data, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      start(VecB, 5'd7);
      wait_done(lat);
      check("post_abort_latency", lat, 7);
      check("post_abort_out", out_data, 64'h0001_0000_0000_000F);
      ack();

      // HALT at address 2
      wr(2, enc(7, 0, 0, 0));
      start(VecA, 5'd7);
      wait_done(lat);
      check("halt_latency", lat, 3);
      check("halt_out", out_data, 64'h0000_3000_0000_00FF);
      ack();

      start(VecA, 5'd0);
      wait_done(lat);
      check("len0_latency", lat, 1);
      check("len0_out", out_data, VecA);
      ack();

      // MOV r0,in3; XOR r0,in1; BNOT r2,r0; NOP; XOR r1,r1 -- prog_len changed after accept
      wr(0, enc(1, 0, 1, 3));
      wr(1, enc(5, 0, 1, 1));
      wr(2, enc(6, 2, 0, 0));
      wr(3, enc(0, 0, 0, 0));
      wr(4, enc(5, 1, 0, 1));
      start(VecA, 5'd5);
      prog_len = 5'd1;
      wait_done(lat);
      check("alu_latency", lat, 5);
      check("alu_out", out_data, 64'hAAAA_5A5A_0000_A5A5);
      ack();

      // Oversized prog_len is clamped to the memory depth
      for (int a = 5; a < 16; a++) wr(a, enc(0, 0, 0, 0));
      start(VecA, 5'd31);
      wait_done(lat);
      check("clamp_latency", lat, 16);
      check("clamp_out", out_data, 64'hAAAA_5A5A_0000_A5A5);
      ack();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
